// File: rtl/pipe_seq.sv
// Pipeline sequencer: arbitrates dmem-wait, load-use, branch and imem-wait
// hazards into per-stage register enables and bubble flushes, with perf counters.
module pipe_seq #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LW_STALL,
    input  logic             BR_TAKEN,
    input  logic             IMEM_READY,
    input  logic             MEM_ACCESS,
    input  logic             DMEM_READY,
    output logic             PC_EN,
    output logic             IF_DEC_EN,
    output logic             DEC_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             IF_FLUSH,
    output logic             DEC_FLUSH,
    output logic             EX_FLUSH,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        BRFLUSH = 2'b10,
        DWAIT   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;
    logic   dmem_wait;
    logic   load_use;
    logic   branch;
    logic   imem_wait;
    logic   br_act;

    // LDSTALL/BRFLUSH mask their own request so each hazard costs exactly one cycle.
    assign dmem_wait = MEM_ACCESS && !DMEM_READY;
    assign load_use  = LW_STALL && (state != LDSTALL);
    assign branch    = BR_TAKEN && (state != BRFLUSH);
    assign imem_wait = !IMEM_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = RUN;
        br_act    = 1'b0;
        PC_EN     = 1'b1;
        IF_DEC_EN = 1'b1;
        DEC_EX_EN = 1'b1;
        EX_MEM_EN = 1'b1;
        MEM_WB_EN = 1'b1;
        IF_FLUSH  = 1'b0;
        DEC_FLUSH = 1'b0;
        EX_FLUSH  = 1'b0;
        if (!RST_N) begin
            PC_EN     = 1'b0;
            IF_DEC_EN = 1'b0;
            DEC_EX_EN = 1'b0;
            EX_MEM_EN = 1'b0;
            MEM_WB_EN = 1'b0;
            IF_FLUSH  = 1'b1;
            DEC_FLUSH = 1'b1;
            EX_FLUSH  = 1'b1;
        end else if (dmem_wait) begin
            PC_EN     = 1'b0;
            IF_DEC_EN = 1'b0;
            DEC_EX_EN = 1'b0;
            EX_MEM_EN = 1'b0;
            MEM_WB_EN = 1'b0;
            state_nxt = DWAIT;
        end else if (load_use) begin
            PC_EN     = 1'b0;
            IF_DEC_EN = 1'b0;
            DEC_EX_EN = 1'b0;
            EX_FLUSH  = 1'b1;
            state_nxt = LDSTALL;
        end else if (branch) begin
            // PC stays enabled even if imem is not ready so the redirect lands.
            br_act    = 1'b1;
            IF_FLUSH  = 1'b1;
            DEC_FLUSH = 1'b1;
            state_nxt = BRFLUSH;
        end else if (imem_wait) begin
            PC_EN     = 1'b0;
            IF_FLUSH  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (!PC_EN && (STALL_CNT != '1)) begin
                STALL_CNT <= STALL_CNT + CNT_ONE;
            end
            if (br_act && (FLUSH_CNT != '1)) begin
                FLUSH_CNT <= FLUSH_CNT + CNT_ONE;
            end
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_pipe_seq.sv
// Directed bench for pipe_seq: hand-computed enable/flush patterns, FSM state
// and saturating counters, with a 4-bit counter instance sharing the stimulus.
module tb_pipe_seq;

    logic        CLK;
    logic        RST_N;
    logic        LW_STALL;
    logic        BR_TAKEN;
    logic        IMEM_READY;
    logic        MEM_ACCESS;
    logic        DMEM_READY;

    logic        PC_EN, IF_DEC_EN, DEC_EX_EN, EX_MEM_EN, MEM_WB_EN;
    logic        IF_FLUSH, DEC_FLUSH, EX_FLUSH;
    logic [1:0]  STATE;
    logic [15:0] STALL_CNT, FLUSH_CNT;

    logic        pc_en4, if_dec_en4, dec_ex_en4, ex_mem_en4, mem_wb_en4;
    logic        if_flush4, dec_flush4, ex_flush4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int errors = 0;
    int checks = 0;

    // {PC,IF_DEC,DEC_EX,EX_MEM,MEM_WB enables, IF,DEC,EX flushes}
    localparam logic [7:0] O_RUN = 8'b11111_000;
    localparam logic [7:0] O_LU  = 8'b00011_001;
    localparam logic [7:0] O_BR  = 8'b11111_110;
    localparam logic [7:0] O_IMW = 8'b01111_100;
    localparam logic [7:0] O_DW  = 8'b00000_000;
    localparam logic [7:0] O_RST = 8'b00000_111;

    pipe_seq dut (
        .CLK(CLK), .RST_N(RST_N), .LW_STALL(LW_STALL), .BR_TAKEN(BR_TAKEN),
        .IMEM_READY(IMEM_READY), .MEM_ACCESS(MEM_ACCESS), .DMEM_READY(DMEM_READY),
        .PC_EN(PC_EN), .IF_DEC_EN(IF_DEC_EN), .DEC_EX_EN(DEC_EX_EN),
        .EX_MEM_EN(EX_MEM_EN), .MEM_WB_EN(MEM_WB_EN),
        .IF_FLUSH(IF_FLUSH), .DEC_FLUSH(DEC_FLUSH), .EX_FLUSH(EX_FLUSH),
        .STATE(STATE), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    pipe_seq #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .LW_STALL(LW_STALL), .BR_TAKEN(BR_TAKEN),
        .IMEM_READY(IMEM_READY), .MEM_ACCESS(MEM_ACCESS), .DMEM_READY(DMEM_READY),
        .PC_EN(pc_en4), .IF_DEC_EN(if_dec_en4), .DEC_EX_EN(dec_ex_en4),
        .EX_MEM_EN(ex_mem_en4), .MEM_WB_EN(mem_wb_en4),
        .IF_FLUSH(if_flush4), .DEC_FLUSH(dec_flush4), .EX_FLUSH(ex_flush4),
        .STATE(state4), .STALL_CNT(stall_cnt4), .FLUSH_CNT(flush_cnt4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] exp);
        chk(tag, {24'b0, PC_EN, IF_DEC_EN, DEC_EX_EN, EX_MEM_EN, MEM_WB_EN,
                  IF_FLUSH, DEC_FLUSH, EX_FLUSH}, {24'b0, exp});
    endtask

    task automatic apply(input logic lw, input logic br, input logic imr,
                         input logic ma, input logic dr);
        LW_STALL   = lw;
        BR_TAKEN   = br;
        IMEM_READY = imr;
        MEM_ACCESS = ma;
        DMEM_READY = dr;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        apply(0, 0, 1, 0, 0);
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        apply(0, 0, 1, 0, 0);
        chk_out("rst_outputs", O_RST);
        tick();
        tick();
        chk("rst_state", {30'b0, STATE}, 32'd0);
        chk("rst_stall", {16'b0, STALL_CNT}, 32'd0);
        chk("rst_flush", {16'b0, FLUSH_CNT}, 32'd0);
        RST_N = 1'b1;
        apply(0, 0, 1, 0, 0);
        chk_out("run_outputs", O_RUN);
        tick();
        chk("run_state", {30'b0, STATE}, 32'd0);

        // load-use held for three cycles
        apply(1, 0, 1, 0, 0);
        chk_out("lu_c0_out", O_LU);
        tick();
        chk("lu_c0_state", {30'b0, STATE}, 32'd1);
        apply(1, 0, 1, 0, 0);
        chk_out("lu_c1_out", O_RUN);
        tick();
        chk("lu_c1_state", {30'b0, STATE}, 32'd0);
        apply(1, 0, 1, 0, 0);
        chk_out("lu_c2_out", O_LU);
        tick();
        chk("lu_stall_cnt", {16'b0, STALL_CNT}, 32'd2);

        // branch held for two cycles
        do_reset();
        apply(0, 1, 1, 0, 0);
        chk_out("br_c0_out", O_BR);
        tick();
        chk("br_c0_state", {30'b0, STATE}, 32'd2);
        apply(0, 1, 1, 0, 0);
        chk_out("br_c1_out", O_RUN);
        tick();
        chk("br_c1_state", {30'b0, STATE}, 32'd0);
        chk("br_flush_cnt", {16'b0, FLUSH_CNT}, 32'd1);
        chk("br_stall_cnt", {16'b0, STALL_CNT}, 32'd0);

        // dmem-wait for four cycles with load-use pending throughout
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 1, 1, 0);
            chk_out($sformatf("dw_c%0d_out", i), O_DW);
            tick();
            chk($sformatf("dw_c%0d_state", i), {30'b0, STATE}, 32'd3);
        end
        apply(1, 0, 1, 0, 0);
        chk_out("dw_lu_out", O_LU);
        tick();
        chk("dw_lu_state", {30'b0, STATE}, 32'd1);
        chk("dw_stall_cnt", {16'b0, STALL_CNT}, 32'd5);

        // load-use and branch together
        do_reset();
        apply(1, 1, 1, 0, 0);
        chk_out("lubr_c0_out", O_LU);
        tick();
        apply(1, 1, 1, 0, 0);
        chk_out("lubr_c1_out", O_BR);
        tick();
        chk("lubr_state", {30'b0, STATE}, 32'd2);
        chk("lubr_flush_cnt", {16'b0, FLUSH_CNT}, 32'd1);
        chk("lubr_stall_cnt", {16'b0, STALL_CNT}, 32'd1);

        // branch beats imem-wait; imem-wait alone
        do_reset();
        apply(0, 1, 0, 0, 0);
        chk_out("br_imw_out", O_BR);
        tick();
        apply(0, 0, 0, 0, 0);
        chk_out("imw_out", O_IMW);
        tick();
        chk("imw_state", {30'b0, STATE}, 32'd0);
        chk("imw_stall_cnt", {16'b0, STALL_CNT}, 32'd1);

        // stall counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(0, 0, 0, 0, 0);
            tick();
            chk($sformatf("sat_stall4_c%0d", i), {28'b0, stall_cnt4},
                (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        chk("sat_stall16", {16'b0, STALL_CNT}, 32'd20);

        // flush counter saturation: held branch fires every other cycle
        do_reset();
        for (int i = 0; i < 34; i++) begin
            apply(0, 1, 1, 0, 0);
            tick();
        end
        chk("sat_flush4", {28'b0, flush_cnt4}, 32'd15);
        chk("sat_flush16", {16'b0, FLUSH_CNT}, 32'd17);

        // reset in the second cycle of dmem-wait
        do_reset();
        apply(0, 0, 1, 1, 0);
        tick();
        apply(1, 0, 1, 0, 0);
        tick();
        apply(0, 0, 1, 1, 0);
        tick();
        chk("dwr_pre_state", {30'b0, STATE}, 32'd3);
        RST_N = 1'b0;
        apply(1, 1, 0, 1, 0);
        chk_out("dwr_rst_out", O_RST);
        tick();
        chk("dwr_state", {30'b0, STATE}, 32'd0);
        chk("dwr_stall", {16'b0, STALL_CNT}, 32'd0);
        chk("dwr_flush", {16'b0, FLUSH_CNT}, 32'd0);
        apply(1, 1, 0, 1, 0);
        chk_out("dwr_rst_hold_out", O_RST);
        RST_N = 1'b1;
        apply(0, 0, 1, 0, 0);
        chk_out("dwr_release_out", O_RUN);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
